// File: rtl/vec_add_avmm.sv
// Vector add/sub engine: C[i] = A[i] +/- B[i] over an Avalon-MM master,
// started and returned through a start/busy/done/stall call handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; busy low
// RD_A   | read request for A[i] held until waitrequest drops
// WT_A   | waiting for A[i] readdata (may already be captured in RD_A)
// RD_B   | read request for B[i] held until waitrequest drops
// WT_B   | waiting for B[i] readdata (may already be captured in RD_B)
// WR_C   | write of C[i] held until waitrequest drops
// DONE   | done high, held while stall is high
module vec_add_avmm #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                stall,
    input  logic [ADDR_W-1:0]   A,
    input  logic [ADDR_W-1:0]   B,
    input  logic [ADDR_W-1:0]   C,
    input  logic [LEN_W-1:0]    N,
    input  logic [1:0]          mode,
    output logic                ovf,
    output logic [ADDR_W-1:0]   avmm_0_rw_address,
    output logic [DATA_W/8-1:0] avmm_0_rw_byteenable,
    output logic                avmm_0_rw_read,
    input  logic [DATA_W-1:0]   avmm_0_rw_readdata,
    input  logic                avmm_0_rw_readdatavalid,
    input  logic                avmm_0_rw_waitrequest,
    output logic                avmm_0_rw_write,
    output logic [DATA_W-1:0]   avmm_0_rw_writedata
);

    localparam int                BE_W    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(BE_W);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_WT_A, S_RD_B, S_WT_B, S_WR_C, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   a_base, b_base, c_base, offset;
    logic [LEN_W-1:0]    remaining;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic                rd_hit;

    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   result;
    logic                elem_ovf;
    logic                last_elem;
    logic                rsp_ready;

    assign last_elem = (remaining == LEN_W'(1));
    // Data already captured alongside the accepted read, or arriving now.
    assign rsp_ready = rd_hit | avmm_0_rw_readdatavalid;

    // Element arithmetic with signed overflow detection and optional saturation;
    // the sign of A decides the saturation direction for both add and subtract.
    always_comb begin
        sum      = mode_q[0] ? (a_q - b_q) : (a_q + b_q);
        elem_ovf = mode_q[0]
                 ? ((a_q[DATA_W-1] != b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]))
                 : ((a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]));
        result   = sum;
        if (elem_ovf && mode_q[1]) begin
            result = a_q[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = (N == '0) ? S_DONE : S_RD_A;
            S_RD_A: if (!avmm_0_rw_waitrequest) state_nxt = S_WT_A;
            S_WT_A: if (rsp_ready) state_nxt = S_RD_B;
            S_RD_B: if (!avmm_0_rw_waitrequest) state_nxt = S_WT_B;
            S_WT_B: if (rsp_ready) state_nxt = S_WR_C;
            S_WR_C: if (!avmm_0_rw_waitrequest) state_nxt = last_elem ? S_DONE : S_RD_A;
            S_DONE: if (!stall) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Argument latch, operand capture, element stepping and sticky overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            offset    <= '0;
            remaining <= '0;
            mode_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_hit    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_base    <= A;
                        b_base    <= B;
                        c_base    <= C;
                        remaining <= N;
                        mode_q    <= mode;
                        offset    <= '0;
                        rd_hit    <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                S_RD_A: begin
                    if (!avmm_0_rw_waitrequest && avmm_0_rw_readdatavalid) begin
                        a_q    <= avmm_0_rw_readdata;
                        rd_hit <= 1'b1;
                    end
                end
                S_WT_A: begin
                    if (avmm_0_rw_readdatavalid && !rd_hit) a_q <= avmm_0_rw_readdata;
                    if (rsp_ready) rd_hit <= 1'b0;
                end
                S_RD_B: begin
                    if (!avmm_0_rw_waitrequest && avmm_0_rw_readdatavalid) begin
                        b_q    <= avmm_0_rw_readdata;
                        rd_hit <= 1'b1;
                    end
                end
                S_WT_B: begin
                    if (avmm_0_rw_readdatavalid && !rd_hit) b_q <= avmm_0_rw_readdata;
                    if (rsp_ready) rd_hit <= 1'b0;
                end
                S_WR_C: begin
                    if (!avmm_0_rw_waitrequest) begin
                        offset    <= offset + STRIDE;
                        remaining <= remaining - LEN_W'(1);
                        if (elem_ovf) ovf <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and bus outputs decoded from state; address and data come from
    // registers only, so they stay put for as long as waitrequest holds a request.
    always_comb begin
        busy                 = (state != S_IDLE);
        done                 = (state == S_DONE);
        avmm_0_rw_read       = 1'b0;
        avmm_0_rw_write      = 1'b0;
        avmm_0_rw_address    = '0;
        avmm_0_rw_writedata  = '0;
        avmm_0_rw_byteenable = '0;
        unique case (state)
            S_RD_A: begin
                avmm_0_rw_read       = 1'b1;
                avmm_0_rw_address    = a_base + offset;
                avmm_0_rw_byteenable = '1;
            end
            S_RD_B: begin
                avmm_0_rw_read       = 1'b1;
                avmm_0_rw_address    = b_base + offset;
                avmm_0_rw_byteenable = '1;
            end
            S_WR_C: begin
                avmm_0_rw_write      = 1'b1;
                avmm_0_rw_address    = c_base + offset;
                avmm_0_rw_writedata  = result;
                avmm_0_rw_byteenable = '1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_vec_add_avmm.sv
// Bench for vec_add_avmm: randomised Avalon-MM slave with waitrequest and
// delayed readdatavalid, a reference model computing expected C elements from
// plain wide-integer arithmetic, and a monitor that scoreboards every write.
module tb_vec_add_avmm;

    logic        clock, resetn, start, busy, done, stall, ovf;
    logic [63:0] A, B, C;
    logic [31:0] N;
    logic [1:0]  mode;
    logic [63:0] address, rdata, wdata;
    logic [7:0]  be;
    logic        rd, wr, rdv, wreq;

    vec_add_avmm #(.DATA_W(64), .ADDR_W(64), .LEN_W(32)) dut (
        .clock                   (clock),
        .resetn                  (resetn),
        .start                   (start),
        .busy                    (busy),
        .done                    (done),
        .stall                   (stall),
        .A                       (A),
        .B                       (B),
        .C                       (C),
        .N                       (N),
        .mode                    (mode),
        .ovf                     (ovf),
        .avmm_0_rw_address       (address),
        .avmm_0_rw_byteenable    (be),
        .avmm_0_rw_read          (rd),
        .avmm_0_rw_readdata      (rdata),
        .avmm_0_rw_readdatavalid (rdv),
        .avmm_0_rw_waitrequest   (wreq),
        .avmm_0_rw_write         (wr),
        .avmm_0_rw_writedata     (wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] exp_addr [$];
    logic [63:0] exp_data [$];
    bit          exp_ovf  [$];

    bit          wait_en = 0;
    int          dmax = 0;
    bit          pend = 0;
    int          pcnt = 0;
    logic [63:0] pdata = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    // Exact signed result in 66 bits, then range check against the 64-bit limits.
    function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] m, output bit ov);
        logic signed [65:0] sa, sb, full, maxv, minv;
        sa   = $signed({{2{a[63]}}, a});
        sb   = $signed({{2{b[63]}}, b});
        maxv = (66'sd1 <<< 63) - 66'sd1;
        minv = -(66'sd1 <<< 63);
        full = m[0] ? (sa - sb) : (sa + sb);
        ov   = (full > maxv) || (full < minv);
        if (ov && m[1]) return (full > 66'sd0) ? maxv[63:0] : minv[63:0];
        return full[63:0];
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            2:       return 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
            default: return 64'($urandom_range(0, 100));
        endcase
    endfunction

    task automatic fill(input logic [63:0] a_b, input logic [63:0] b_b, input int n);
        for (int i = 0; i < n; i++) begin
            mem[a_b + 64'(i) * 64'd8] = rnd_val();
            mem[b_b + 64'(i) * 64'd8] = rnd_val();
        end
    endtask

    task automatic expect_call(input logic [63:0] a_b, input logic [63:0] b_b,
                               input logic [63:0] c_b, input int n, input logic [1:0] m);
        bit ov_all;
        bit ov;
        logic [63:0] r;
        ov_all = 0;
        for (int i = 0; i < n; i++) begin
            r = ref_op(rd_mem(a_b + 64'(i) * 64'd8), rd_mem(b_b + 64'(i) * 64'd8), m, ov);
            exp_addr.push_back(c_b + 64'(i) * 64'd8);
            exp_data.push_back(r);
            ov_all = ov_all | ov;
        end
        exp_ovf.push_back(ov_all);
    endtask

    task automatic finish_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic run_call(input logic [63:0] a_b, input logic [63:0] b_b, input logic [63:0] c_b,
                            input int n, input logic [1:0] m, input int stall_cyc,
                            input int exp_lat, input string tag);
        int cyc;
        expect_call(a_b, b_b, c_b, n, m);
        @(negedge clock);
        check({tag, "_idle_before"}, 64'(busy), 64'd0);
        A = a_b; B = b_b; C = c_b; N = 32'(n); mode = m;
        stall = (stall_cyc > 0);
        start = 1'b1;
        @(negedge clock);
        cyc   = 1;
        start = 1'b0;
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; C = {$urandom, $urandom};
        N = $urandom; mode = 2'($urandom);
        while (!done && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
        if (!done) finish_now({tag, "_done_timeout"});
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        if (stall_cyc > 0) begin
            for (int k = 0; k < stall_cyc; k++) begin
                @(negedge clock);
                check({tag, "_stall_hold"}, {62'd0, done, busy}, 64'd3);
                if (k == stall_cyc / 2) begin
                    start = 1'b1;
                    A = 64'h0050_0000; B = 64'h0060_0000; C = 64'h0070_0000;
                    N = 32'd5; mode = 2'd0;
                end
            end
            stall = 1'b0;
            @(negedge clock);
            start = 1'b0;
            check({tag, "_return"}, {62'd0, busy, done}, 64'd0);
            repeat (3) @(negedge clock);
            check({tag, "_start_ignored"}, 64'(busy), 64'd0);
        end else begin
            @(negedge clock);
            check({tag, "_return"}, {62'd0, busy, done}, 64'd0);
        end
    endtask

    // Slave: decides waitrequest each cycle and returns read data 0..dmax cycles
    // after acceptance (0 means in the acceptance cycle itself).
    always begin : slave
        int d;
        logic [63:0] v;
        @(posedge clock);
        #1;
        rdv = 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                rdv   = 1'b1;
                rdata = pdata;
                pend  = 0;
            end else begin
                pcnt--;
            end
        end
        wreq = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rd && !wreq) begin
            d = (dmax > 0) ? int'($urandom_range(0, dmax)) : 0;
            v = rd_mem(address);
            if (d == 0) begin
                rdv   = 1'b1;
                rdata = v;
            end else begin
                pend  = 1;
                pcnt  = d;
                pdata = v;
            end
        end
    end

    // Monitor: scoreboards accepted writes, checks request hold under waitrequest,
    // and checks the sticky overflow flag when done rises.
    always begin : monitor
        bit          done_q, prev_wstall, prev_rstall;
        logic [63:0] prev_waddr, prev_wdata, prev_raddr;
        @(negedge clock);
        if (!resetn) begin
            done_q = 0; prev_wstall = 0; prev_rstall = 0;
        end else begin
            if (rd || wr) begin
                check("rd_wr_exclusive", 64'(rd & wr), 64'd0);
                check("byteenable", 64'(be), 64'hFF);
            end
            if (prev_wstall) begin
                check("wr_hold_req", 64'(wr), 64'd1);
                check("wr_hold_addr", address, prev_waddr);
                check("wr_hold_data", wdata, prev_wdata);
            end
            if (prev_rstall) begin
                check("rd_hold_req", 64'(rd), 64'd1);
                check("rd_hold_addr", address, prev_raddr);
            end
            prev_wstall = wr && wreq;
            prev_waddr  = address;
            prev_wdata  = wdata;
            prev_rstall = rd && wreq;
            prev_raddr  = address;
            if (wr && !wreq) begin
                wr_count++;
                mem[address] = wdata;
                if (exp_addr.size() == 0) begin
                    check("unexpected_write_addr", address, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("wr_addr", address, exp_addr.pop_front());
                    check("wr_data", wdata, exp_data.pop_front());
                end
            end
            if (done && !done_q) begin
                check("writes_complete_at_done", 64'(exp_addr.size()), 64'd0);
                if (exp_ovf.size() == 0) check("unexpected_done", 64'(done), 64'd0);
                else check("ovf_at_done", 64'(ovf), 64'(exp_ovf.pop_front()));
            end
            done_q = done;
        end
    end

    initial begin : watchdog
        #900_000;
        finish_now("global_timeout");
    end

    initial begin : main
        bit found;
        int wsnap;
        logic [63:0] rb;
        resetn = 1'b0; start = 1'b0; stall = 1'b0;
        A = '0; B = '0; C = '0; N = '0; mode = '0;
        rdv = 1'b0; wreq = 1'b0; rdata = '0;
        #12;
        check("rst_ctrl", {51'd0, busy, done, ovf, rd, wr, be}, 64'd0);
        check("rst_addr", address, 64'd0);
        check("rst_wdata", wdata, 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Basic add, no waits, exact latency 5N+1.
        for (int i = 0; i < 4; i++) begin
            mem[64'h1000 + 64'(i) * 8] = 64'(i + 1);
            mem[64'h2000 + 64'(i) * 8] = 64'(10 * (i + 1));
        end
        run_call(64'h1000, 64'h2000, 64'h3000, 4, 2'd0, 0, 21, "t1");
        for (int i = 0; i < 4; i++)
            check("t1_c_value", rd_mem(64'h3000 + 64'(i) * 8), 64'(11 * (i + 1)));
        check("t1_ovf", 64'(ovf), 64'd0);

        // Empty vector.
        run_call(64'h1000, 64'h2000, 64'h3800, 0, 2'd0, 0, 1, "t2");
        check("t2_ovf", 64'(ovf), 64'd0);
        check("t2_no_write", 64'(mem.exists(64'h3800)), 64'd0);

        // Overflow: saturating subtract, wrapping subtract, saturating add.
        mem[64'h5000] = 64'h8000_0000_0000_0000;
        mem[64'h6000] = 64'h1;
        run_call(64'h5000, 64'h6000, 64'h7000, 1, 2'd3, 0, 6, "t3a");
        check("t3a_sat_min", rd_mem(64'h7000), 64'h8000_0000_0000_0000);
        check("t3a_ovf", 64'(ovf), 64'd1);
        run_call(64'h5000, 64'h6000, 64'h7100, 1, 2'd1, 0, 6, "t3b");
        check("t3b_wrap", rd_mem(64'h7100), 64'h7FFF_FFFF_FFFF_FFFF);
        check("t3b_ovf", 64'(ovf), 64'd1);
        mem[64'h5100] = 64'h7FFF_FFFF_FFFF_FFFF;
        run_call(64'h5100, 64'h6000, 64'h7200, 1, 2'd2, 0, 6, "t3c");
        check("t3c_sat_max", rd_mem(64'h7200), 64'h7FFF_FFFF_FFFF_FFFF);

        // Return stalled for 10 cycles with a start attempted meanwhile.
        fill(64'h8000, 64'h8800, 2);
        run_call(64'h8000, 64'h8800, 64'h9000, 2, 2'd0, 10, 11, "t5");

        // Random waitrequest and read latency, random modes, one wrapping base.
        wait_en = 1; dmax = 7;
        for (int k = 0; k < 4; k++) begin
            logic [63:0] ab;
            ab = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFC0 : 64'h10_0000 + 64'(k) * 64'h1000;
            fill(ab, 64'h20_0000 + 64'(k) * 64'h1000, 16);
            run_call(ab, 64'h20_0000 + 64'(k) * 64'h1000, 64'h30_0000 + 64'(k) * 64'h1000,
                     16, 2'($urandom), 0, -1, "t4");
        end
        wait_en = 0; dmax = 0;

        // Reset during the write of element 2 aborts the call.
        fill(64'hA000, 64'hB000, 4);
        expect_call(64'hA000, 64'hB000, 64'hC000, 4, 2'd0);
        @(negedge clock);
        A = 64'hA000; B = 64'hB000; C = 64'hC000; N = 32'd4; mode = 2'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clock);
            #3;
            if (wr && address == 64'hC010) found = 1;
        end
        check("t6_reach_wr2", 64'(found), 64'd1);
        resetn = 1'b0;
        #1;
        check("t6_rst_ctrl", {51'd0, busy, done, ovf, rd, wr, be}, 64'd0);
        check("t6_rst_addr", address, 64'd0);
        check("t6_rst_wdata", wdata, 64'd0);
        exp_addr.delete(); exp_data.delete(); exp_ovf.delete();
        pend  = 0;
        wsnap = wr_count;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        pend = 1; pcnt = 1; pdata = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (6) @(negedge clock);
        check("t6_no_write", 64'(wr_count), 64'(wsnap));
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_c2_unwritten", 64'(mem.exists(64'hC010)), 64'd0);
        fill(64'hD000, 64'hD800, 4);
        run_call(64'hD000, 64'hD800, 64'hE000, 4, 2'd1, 0, 21, "t6_recall");
        rb = rd_mem(64'hD000) - rd_mem(64'hD800);
        check("t6_recall_c0", rd_mem(64'hE000), rb);

        repeat (3) @(negedge clock);
        check("queues_drained", 64'(exp_addr.size() + exp_ovf.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
